modport_ram: RTL and testbench

MODPORT_RAM -- requirements
Module: modport_ram

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_array.sv | 28 ++
 rtl/modport_ram.sv | 58 +++++
 tb/tb_modport_ram.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the modport_ram block.
//   DATA_WIDTH / ADDR_WIDTH / DEPTH : default geometry (4096 x 64)
//   addr_t / data_t                 : address and word types at that geometry
package ram_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/ram_array.sv
// Storage for modport_ram: DEPTH x DATA_WIDTH words.
//   clock  : write clock (rising edge)
//   we     : write enable, already qualified by the caller
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : combinational read of mem[raddr]
// The array has no reset, so its contents survive a reset pulse.
module ram_array #(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ram_pkg::DEPTH
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/modport_ram.sv
// Simple dual-port RAM, one clock domain, one-cycle registered read.
//   clock      : single clock, rising edge
//   resetn     : asynchronous active-low reset; clears data_out only
//   write      : write enable
//   wr_address : write address
//   data_in    : write data
//   read       : read enable; data_out updates one clock after it is sampled
//   rd_address : read address
//   data_out   : registered read data, held while read=0
// A same-cycle read and write to one address returns the new data (write-first).
module modport_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ram_pkg::DEPTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic                  we;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rd_next;

  // Writes sampled while reset is asserted are dropped.
  assign we = write & resetn;

  ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clock(clock),
    .we   (we),
    .waddr(wr_address),
    .wdata(data_in),
    .raddr(rd_address),
    .rdata(rd_data)
  );

  // The array only updates at the edge, so a colliding read would see stale
  // data; forward the incoming word instead.
  always_comb begin
    rd_next = rd_data;
    if (write && (wr_address == rd_address)) rd_next = data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   data_out <= '0;
    else if (read) data_out <= rd_next;
  end
endmodule

// File: tb/tb_modport_ram.sv
// Directed bench for modport_ram: inputs change on the falling edge,
// data_out is sampled 1ns after the rising edge.
module tb_modport_ram;
  localparam int DW = 64;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          resetn;
  logic          write;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] data_in;
  logic          read;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] data_out;

  int checks   = 0;
  int failures = 0;

  modport_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1 << AW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .write     (write),
    .wr_address(wr_address),
    .data_in   (data_in),
    .read      (read),
    .rd_address(rd_address),
    .data_out  (data_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, return 1ns after the rising edge.
  task automatic cyc(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic rd, input logic [AW-1:0] ra);
    @(negedge clock);
    write = wr; wr_address = wa; data_in = wd;
    read = rd;  rd_address = ra;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; write = 1'b0; read = 1'b0;
    wr_address = '0; rd_address = '0; data_in = '0;
    #1;
    chk("reset_state", data_out, 64'h0);
    @(posedge clock); #1;
    chk("reset_hold", data_out, 64'h0);
    @(negedge clock);
    resetn = 1'b1;

    // basic write then read
    cyc(1, 12'h005, 64'hDEAD_BEEF_0123_4567, 0, 12'h000);
    chk("no_read_yet", data_out, 64'h0);
    cyc(0, 12'h000, 64'h0, 1, 12'h005);
    chk("rd_005", data_out, 64'hDEAD_BEEF_0123_4567);

    // address extremes, no aliasing
    cyc(1, 12'h000, 64'h1, 0, 12'h000);
    cyc(1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 12'h000);
    cyc(0, 12'h000, 64'h0, 1, 12'h000);
    chk("rd_000", data_out, 64'h1);
    cyc(0, 12'h000, 64'h0, 1, 12'hFFF);
    chk("rd_fff", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(0, 12'h000, 64'h0, 1, 12'h000);
    chk("rd_000_again", data_out, 64'h1);

    // same-address collision: write-first
    cyc(1, 12'h010, 64'hA, 0, 12'h000);
    cyc(1, 12'h010, 64'hB, 1, 12'h010);
    chk("collide_wf", data_out, 64'hB);
    cyc(0, 12'h000, 64'h0, 1, 12'h010);
    chk("collide_stored", data_out, 64'hB);

    // different-address read and write in the same cycle
    cyc(1, 12'h021, 64'h66, 0, 12'h000);
    cyc(1, 12'h020, 64'h55, 1, 12'h021);
    chk("dual_rd_021", data_out, 64'h66);
    cyc(0, 12'h000, 64'h0, 1, 12'h020);
    chk("dual_rd_020", data_out, 64'h55);

    // hold while read=0; write=0 with live address/data must not store
    cyc(1, 12'h030, 64'h77, 0, 12'h000);
    cyc(0, 12'h000, 64'h0, 1, 12'h030);
    chk("hold_load", data_out, 64'h77);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 12'h030, 64'hBAD, 0, 12'h005);
      chk($sformatf("hold_%0d", i), data_out, 64'h77);
    end
    cyc(0, 12'h000, 64'h0, 1, 12'h030);
    chk("no_write_kept", data_out, 64'h77);

    // asynchronous reset mid-cycle, memory retained, accesses ignored
    cyc(0, 12'h000, 64'h0, 1, 12'h005);
    chk("pre_reset", data_out, 64'hDEAD_BEEF_0123_4567);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_clear", data_out, 64'h0);
    @(negedge clock);
    write = 1'b1; wr_address = 12'h005; data_in = 64'h1234;
    read = 1'b1;  rd_address = 12'h005;
    @(posedge clock); #1;
    chk("reset_ignores_rd", data_out, 64'h0);
    @(negedge clock);
    write = 1'b0; read = 1'b0;
    resetn = 1'b1;
    cyc(0, 12'h000, 64'h0, 1, 12'h005);
    chk("retain_005", data_out, 64'hDEAD_BEEF_0123_4567);
    cyc(0, 12'h000, 64'h0, 1, 12'h021);
    chk("retain_021", data_out, 64'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
